mem_access_unit: RTL and testbench

Sequencer that sits directly upstream of the 16-word data memory and is the only block that drives its enable, write-enable, address and write-data pins. It accepts single LOAD/STORE requests and block COPY requests from the control unit. It converts each request into correctly timed memory cycles, registers load results for register-file writeback, and signals completion with a one-cycle done pulse.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Control-unit request/response bundle for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [AW-1:0] src;
    logic [AW-1:0] len;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          rdata_valid;

    modport master (
        output req, op, addr, src, len, wdata,
        input  busy, done, rdata, rdata_valid
    );

    modport slave (
        input  req, op, addr, src, len, wdata,
        output busy, done, rdata, rdata_valid
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : LOAD/STORE/COPY sequencer driving the 16-word data memory pins.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_unit_if.slave   cu,
    output logic               mem_E,
    output logic               mem_WE,
    output logic [AW-1:0]      mem_Addr,
    output logic [DW-1:0]      mem_Din,
    input  wire logic [DW-1:0] mem_Dout
);

    localparam logic [1:0] c_OP_NONE  = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_STORE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_CPY_RD = 3'd3,
        S_CPY_WR = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_dst_ptr;   // LOAD/STORE address, COPY destination pointer
    logic [AW-1:0] r_src_ptr;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_buf;
    logic [DW-1:0] r_rdata;
    logic          r_done;
    logic          r_rdata_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_dst_ptr     <= '0;
            r_src_ptr     <= '0;
            r_cnt         <= '0;
            r_wdata       <= '0;
            r_buf         <= '0;
            r_rdata       <= '0;
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cu.req && (cu.op != c_OP_NONE)) begin
                        r_dst_ptr <= cu.addr;
                        r_src_ptr <= cu.src;
                        r_cnt     <= cu.len;
                        r_wdata   <= cu.wdata;
                        case (cu.op)
                            c_OP_LOAD:  r_state <= S_LOAD;
                            c_OP_STORE: r_state <= S_STORE;
                            default: begin
                                // Zero-length copy completes without touching memory
                                if (cu.len == '0) r_done  <= 1'b1;
                                else              r_state <= S_CPY_RD;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    r_rdata       <= mem_Dout;
                    r_done        <= 1'b1;
                    r_rdata_valid <= 1'b1;
                    r_state       <= S_IDLE;
                end
                S_STORE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_CPY_RD: begin
                    r_buf   <= mem_Dout;
                    r_state <= S_CPY_WR;
                end
                S_CPY_WR: begin
                    r_src_ptr <= r_src_ptr + AW'(1);
                    r_dst_ptr <= r_dst_ptr + AW'(1);
                    r_cnt     <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_CPY_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory pins decode only from registered state so reset drops them at once
    always_comb begin
        mem_E    = 1'b0;
        mem_WE   = 1'b0;
        mem_Addr = '0;
        mem_Din  = '0;
        case (r_state)
            S_LOAD: begin
                mem_E    = 1'b1;
                mem_Addr = r_dst_ptr;
            end
            S_STORE: begin
                mem_E    = 1'b1;
                mem_WE   = 1'b1;
                mem_Addr = r_dst_ptr;
                mem_Din  = r_wdata;
            end
            S_CPY_RD: begin
                mem_E    = 1'b1;
                mem_Addr = r_src_ptr;
            end
            S_CPY_WR: begin
                mem_E    = 1'b1;
                mem_WE   = 1'b1;
                mem_Addr = r_dst_ptr;
                mem_Din  = r_buf;
            end
            default: ;
        endcase
    end

    assign cu.busy        = (r_state != S_IDLE);
    assign cu.done        = r_done;
    assign cu.rdata       = r_rdata;
    assign cu.rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit with a 16x8 memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_E, mem_WE;
    logic [3:0] mem_Addr;
    logic [7:0] mem_Din, mem_Dout;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] model [16] = '{default: 8'h00};
    logic [7:0] model_rdata = 8'h00;

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic       ld;
        logic [7:0] rd;
    } done_t;

    done_t       exp_q [$];
    logic [11:0] wr_q  [$];
    logic [3:0]  rd_q  [$];

    mem_access_unit_if #(.AW(4), .DW(8)) cu ();

    mem_access_unit #(.AW(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cu       (cu),
        .mem_E    (mem_E),
        .mem_WE   (mem_WE),
        .mem_Addr (mem_Addr),
        .mem_Din  (mem_Din),
        .mem_Dout (mem_Dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_Dout = mem[mem_Addr];
    always @(posedge clk) if (mem_E && mem_WE) mem[mem_Addr] <= mem_Din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses as the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            if (cu.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    done_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("rdata_valid", {31'd0, cu.rdata_valid}, {31'd0, e.ld});
                    check("rdata", {24'd0, cu.rdata}, {24'd0, e.rd});
                    check("busy_in_done", {31'd0, cu.busy}, 32'd0);
                end
            end else if (cu.rdata_valid) begin
                check("stray_rdata_valid", 32'd1, 32'd0);
            end
            if (mem_E && mem_WE) begin
                if (wr_q.size() == 0) check("spurious_write", {20'd0, mem_Addr, mem_Din}, 32'hFFF);
                else check("write_addr_data", {20'd0, mem_Addr, mem_Din}, {20'd0, wr_q.pop_front()});
            end else if (mem_E) begin
                if (rd_q.size() == 0) check("spurious_read", {28'd0, mem_Addr}, 32'hF);
                else check("read_addr", {28'd0, mem_Addr}, {28'd0, rd_q.pop_front()});
            end
        end
    end

    // Drive one request in the current cycle and record what must follow
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] s,
                         input logic [3:0] l, input logic [7:0] wd);
        done_t e;
        cu.req = 1'b1; cu.op = op; cu.addr = a; cu.src = s; cu.len = l; cu.wdata = wd;
        e.ld = 1'b0;
        case (op)
            2'b01: begin
                e.cyc = cyc + 2; e.ld = 1'b1;
                model_rdata = model[a];
                rd_q.push_back(a);
            end
            2'b10: begin
                e.cyc = cyc + 2;
                model[a] = wd;
                wr_q.push_back({a, wd});
            end
            default: begin
                e.cyc = cyc + 1 + 2 * int'(l);
                for (int i = 0; i < int'(l); i++) begin
                    logic [3:0] sp, dp;
                    sp = s + 4'(i);
                    dp = a + 4'(i);
                    rd_q.push_back(sp);
                    model[dp] = model[sp];
                    wr_q.push_back({dp, model[sp]});
                end
            end
        endcase
        e.rd = model_rdata;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cu.req = 1'b0; cu.op = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !cu.busy) return;
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (cu.done) return;
        end
        check("wait_done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        cu.req = 1'b0; cu.op = 2'b00; cu.addr = '0; cu.src = '0; cu.len = '0; cu.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, cu.busy}, 32'd0);
        check("rst_done", {31'd0, cu.done}, 32'd0);
        check("rst_rdata", {24'd0, cu.rdata}, 32'd0);
        check("rst_rdata_valid", {31'd0, cu.rdata_valid}, 32'd0);
        check("rst_mem_pins", {18'd0, mem_E, mem_WE, mem_Addr, mem_Din}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // STORE then LOAD of the same word
        issue(2'b10, 4'd3, 4'd0, 4'd0, 8'hA5);
        check("store_busy", {31'd0, cu.busy}, 32'd1);
        wait_idle();
        issue(2'b01, 4'd3, 4'd0, 4'd0, 8'h00);
        wait_idle();
        check("load_rdata_hold", {24'd0, cu.rdata}, 32'hA5);

        // Preload words 0..3
        issue(2'b10, 4'd0, 4'd0, 4'd0, 8'h11); wait_idle();
        issue(2'b10, 4'd1, 4'd0, 4'd0, 8'h22); wait_idle();
        issue(2'b10, 4'd2, 4'd0, 4'd0, 8'h33); wait_idle();
        issue(2'b10, 4'd3, 4'd0, 4'd0, 8'h44); wait_idle();

        // Back-to-back: LOAD issued in the STORE's done cycle
        issue(2'b10, 4'd5, 4'd0, 4'd0, 8'h5A);
        wait_done();
        issue(2'b01, 4'd5, 4'd0, 4'd0, 8'h00);
        wait_idle();
        check("b2b_rdata", {24'd0, cu.rdata}, 32'h5A);

        // COPY 0..3 -> 8..11 with requests hammered while busy
        issue(2'b11, 4'd8, 4'd0, 4'd4, 8'h00);
        cu.req = 1'b1; cu.op = 2'b01; cu.addr = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        check("busy_during_copy", {31'd0, cu.busy}, 32'd1);
        cu.req = 1'b0; cu.op = 2'b00;
        wait_idle();
        check("copy_w8",  {24'd0, mem[8]},  32'h11);
        check("copy_w9",  {24'd0, mem[9]},  32'h22);
        check("copy_w10", {24'd0, mem[10]}, 32'h33);
        check("copy_w11", {24'd0, mem[11]}, 32'h44);
        check("copy_rdata_kept", {24'd0, cu.rdata}, 32'h5A);

        // op=00 request in IDLE is ignored
        cu.req = 1'b1; cu.op = 2'b00; cu.addr = 4'd7;
        repeat (3) begin
            @(posedge clk); #1;
            check("op00_ignored_busy", {31'd0, cu.busy}, 32'd0);
        end
        cu.req = 1'b0;

        // Wrapping COPY: reads 14,15,0 and writes 2,3,4
        issue(2'b10, 4'd14, 4'd0, 4'd0, 8'hE1); wait_idle();
        issue(2'b10, 4'd15, 4'd0, 4'd0, 8'hF2); wait_idle();
        issue(2'b11, 4'd2, 4'd14, 4'd3, 8'h00);
        wait_idle();
        check("wrap_w2", {24'd0, mem[2]}, 32'hE1);
        check("wrap_w3", {24'd0, mem[3]}, 32'hF2);
        check("wrap_w4", {24'd0, mem[4]}, 32'h11);

        // Zero-length COPY completes in one cycle with no memory traffic
        issue(2'b11, 4'd6, 4'd1, 4'd0, 8'h00);
        wait_idle();

        // Reset asserted during CPY_WR aborts the write
        issue(2'b11, 4'd12, 4'd0, 4'd1, 8'h00);
        @(posedge clk); #1;
        check("cpywr_we_before_rst", {30'd0, mem_E, mem_WE}, 32'd3);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_E", {31'd0, mem_E}, 32'd0);
        check("rst_mid_busy", {31'd0, cu.busy}, 32'd0);
        check("rst_mid_rdata", {24'd0, cu.rdata}, 32'd0);
        @(posedge clk); #1;
        check("rst_target_unwritten", {24'd0, mem[12]}, 32'd0);
        exp_q.delete();
        wr_q.delete();
        rd_q.delete();
        model[12] = 8'h00;
        model_rdata = 8'h00;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b01, 4'd9, 4'd0, 4'd0, 8'h00);
        wait_idle();
        check("post_rst_load", {24'd0, cu.rdata}, 32'h22);

        $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
